// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC gateway array.
package plic_pkg;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    localparam int GW_NO_ID = 0;

    function automatic int id_width(input int sources);
        return $clog2(sources + 1);
    endfunction

endpackage

// File: rtl/plic_gateway_cell.sv
// One interrupt gateway: request FSM, src history, saturating edge counter.
// Optional 2-flop src synchroniser when PLIC_GW_SYNC_EN is defined.
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int MAX_PENDING_COUNT = 4
) (
    input  logic h_clk,
    input  logic h_rst,
    input  logic src,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic ip,
    output logic busy
);

    localparam int CNT_W = (MAX_PENDING_COUNT > 0) ? $clog2(MAX_PENDING_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

    logic             src_s;
    logic             src_d;
    logic             mode_q;
    logic             mode_eff;
    logic             rise;
    logic             req;
    logic             cnt_full;
    logic             cnt_nz;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    gw_state_e        state;
    gw_state_e        state_nx;

`ifdef PLIC_GW_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], src};
        end
    end

    assign src_s = sync_q[1];
`else
    assign src_s = src;
`endif

    // Mode is frozen while busy; a new edge_mode value only applies from IDLE.
    assign mode_eff = (state == GW_IDLE) ? edge_mode : mode_q;
    assign rise     = src_s & ~src_d;
    assign req      = mode_eff ? rise : src_s;
    assign cnt_full = (cnt == CNT_MAX);
    assign cnt_nz   = (cnt != '0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            GW_IDLE: begin
                if (req) state_nx = GW_PENDING;
            end
            GW_PENDING: begin
                if (claim) state_nx = GW_CLAIMED;
                if (mode_eff && rise && !cnt_full) cnt_nx = cnt + 1'b1;
            end
            GW_CLAIMED: begin
                if (complete) begin
                    if (mode_eff) begin
                        // A fresh edge re-arms by itself; otherwise one queued edge is consumed.
                        state_nx = (cnt_nz || rise) ? GW_PENDING : GW_IDLE;
                        if (cnt_nz && !rise) cnt_nx = cnt - 1'b1;
                    end else begin
                        state_nx = src_s ? GW_PENDING : GW_IDLE;
                    end
                end else if (mode_eff && rise && !cnt_full) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = GW_IDLE;
        endcase
        if (!mode_eff) cnt_nx = '0;
    end

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            state  <= GW_IDLE;
            cnt    <= '0;
            src_d  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            src_d <= src_s;
            if (state == GW_IDLE) mode_q <= edge_mode;
        end
    end

    assign ip   = (state == GW_PENDING);
    assign busy = (state != GW_IDLE);

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway array: one gateway cell per source, claim/complete ID decode.
// Define PLIC_GW_SYNC_EN to synchronise src inside each cell (3-cycle request latency).
module plic_gateway
    import plic_pkg::*;
#(
    parameter int SOURCES           = 8,
    parameter int MAX_PENDING_COUNT = 4,
    parameter int ID_W              = id_width(SOURCES)
) (
    input  logic               h_clk,
    input  logic               h_rst,
    input  logic [SOURCES-1:0] src,
    input  logic [SOURCES-1:0] edge_mode,
    output logic [SOURCES-1:0] ip,
    input  logic               claim_valid,
    input  logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id,
    output logic [SOURCES-1:0] busy
);

    logic [SOURCES-1:0] claim_hit;
    logic [SOURCES-1:0] complete_hit;

    // Source bit i answers to ID i+1; ID 0 and IDs above SOURCES match nothing.
    for (genvar i = 0; i < SOURCES; i++) begin : g_cell
        assign claim_hit[i]    = claim_valid && (claim_id != ID_W'(GW_NO_ID))
                                 && (claim_id == ID_W'(i + 1));
        assign complete_hit[i] = complete_valid && (complete_id != ID_W'(GW_NO_ID))
                                 && (complete_id == ID_W'(i + 1));

        plic_gateway_cell #(
            .MAX_PENDING_COUNT(MAX_PENDING_COUNT)
        ) u_cell (
            .h_clk    (h_clk),
            .h_rst    (h_rst),
            .src      (src[i]),
            .edge_mode(edge_mode[i]),
            .claim    (claim_hit[i]),
            .complete (complete_hit[i]),
            .ip       (ip[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed-vector bench for plic_gateway (default build: SOURCES=8, MAX_PENDING_COUNT=4, no sync).
module tb_plic_gateway;

    localparam int SOURCES = 8;
    localparam int ID_W    = 4;

    logic               h_clk = 1'b0;
    logic               h_rst;
    logic [SOURCES-1:0] src;
    logic [SOURCES-1:0] edge_mode;
    logic [SOURCES-1:0] ip;
    logic               claim_valid;
    logic [ID_W-1:0]    claim_id;
    logic               complete_valid;
    logic [ID_W-1:0]    complete_id;
    logic [SOURCES-1:0] busy;

    int n_vec = 0;
    int n_err = 0;

    plic_gateway #(
        .SOURCES(SOURCES),
        .MAX_PENDING_COUNT(4)
    ) u_dut (
        .h_clk         (h_clk),
        .h_rst         (h_rst),
        .src           (src),
        .edge_mode     (edge_mode),
        .ip            (ip),
        .claim_valid   (claim_valid),
        .claim_id      (claim_id),
        .complete_valid(complete_valid),
        .complete_id   (complete_id),
        .busy          (busy)
    );

    always #5 h_clk = ~h_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge h_clk);
        #1;
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic do_claim(input int id);
        claim_valid = 1'b1;
        claim_id    = ID_W'(id);
        step();
    endtask

    task automatic do_complete(input int id);
        complete_valid = 1'b1;
        complete_id    = ID_W'(id);
        step();
    endtask

    task automatic pulse(input logic [SOURCES-1:0] bits);
        src = bits;
        step();
        src = '0;
        step();
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_ip, input logic [7:0] exp_busy);
        check_eq({tag, ".ip"},   32'(ip),   32'(exp_ip));
        check_eq({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        h_rst          = 1'b1;
        src            = '0;
        edge_mode      = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        step();
        step();
        check_out("reset", 8'h00, 8'h00);
        h_rst = 1'b0;

        // 1: level one-cycle pulse on source bit 2 (ID 3)
        src = 8'h04;
        step();
        check_out("t1_req", 8'h04, 8'h04);
        src = '0;
        step();
        check_out("t1_held", 8'h04, 8'h04);
        do_claim(3);
        check_out("t1_claim", 8'h00, 8'h04);
        do_complete(3);
        check_out("t1_done", 8'h00, 8'h00);

        // 2: level held high through claim/complete re-raises ip
        src = 8'h01;
        step();
        check_out("t2_req", 8'h01, 8'h01);
        do_claim(1);
        check_out("t2_claim", 8'h00, 8'h01);
        do_complete(1);
        check_out("t2_rearm", 8'h01, 8'h01);
        do_claim(1);
        src = '0;
        do_complete(1);
        check_out("t2_done", 8'h00, 8'h00);

        // 3: edge source bit 4 (ID 5), 6 pulses while claimed, saturate at 4
        edge_mode = 8'h10;
        pulse(8'h10);
        check_out("t3_req", 8'h10, 8'h10);
        do_claim(5);
        check_out("t3_claim", 8'h00, 8'h10);
        for (int k = 0; k < 6; k++) pulse(8'h10);
        check_out("t3_queued", 8'h00, 8'h10);
        for (int k = 0; k < 4; k++) begin
            do_complete(5);
            check_out($sformatf("t3_rearm%0d", k), 8'h10, 8'h10);
            do_claim(5);
        end
        do_complete(5);
        check_out("t3_idle", 8'h00, 8'h00);

        // 4: edge + complete in the same cycle with cnt=1
        pulse(8'h10);
        do_claim(5);
        pulse(8'h10);
        src = 8'h10;
        do_complete(5);
        check_out("t4_same", 8'h10, 8'h10);
        src = '0;
        do_claim(5);
        do_complete(5);
        check_out("t4_cnt1", 8'h10, 8'h10);
        do_claim(5);
        do_complete(5);
        check_out("t4_idle", 8'h00, 8'h00);

        // 5: ignored IDs and complete of a pending source; same-cycle claim+complete
        src = 8'h02;
        step();
        src = '0;
        check_out("t5_req", 8'h02, 8'h02);
        do_claim(0);
        check_out("t5_id0", 8'h02, 8'h02);
        do_claim(9);
        check_out("t5_id9", 8'h02, 8'h02);
        do_complete(2);
        check_out("t5_cmp_pend", 8'h02, 8'h02);
        claim_valid = 1'b1;
        claim_id    = 4'd2;
        do_complete(2);
        check_out("t5_both", 8'h00, 8'h02);
        do_complete(2);
        check_out("t5_done", 8'h00, 8'h00);

        // 6: reset while three edge sources pending with cnt=2
        edge_mode = 8'hE0;
        pulse(8'hE0);
        pulse(8'hE0);
        pulse(8'hE0);
        check_out("t6_pend", 8'hE0, 8'hE0);
        h_rst = 1'b1;
        do_claim(6);
        check_out("t6_rst", 8'h00, 8'h00);
        h_rst = 1'b0;
        step();
        check_out("t6_quiet", 8'h00, 8'h00);
        pulse(8'hE0);
        do_claim(6);
        do_complete(6);
        check_out("t6_cnt0", 8'hC0, 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
